// File: rtl/i2c_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_if
//  Purpose  : Bundles the I2C pin levels and the local byte handshake that
//             connect an i2c_slave target to its pads and to local logic.
//  Signals  : scl_in, sda_in  - raw pin levels (asynchronous to ref_clk)
//             sda_oe          - 1 = pull SDA low, 0 = release (open drain)
//             busy, rw        - transaction status of the target
//             rx_data/rx_valid- byte written by the bus master
//             tx_data/tx_req  - byte supplied for a master read
//  Modports : slave  - the target endpoint
//             master - pads plus local logic around the target
//  Revision : 1.0 - initial release
// ============================================================================
interface i2c_slave_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       busy;
    logic       rw;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;

    modport slave (
        input  scl_in,
        input  sda_in,
        input  tx_data,
        output sda_oe,
        output busy,
        output rw,
        output rx_data,
        output rx_valid,
        output tx_req
    );

    modport master (
        output scl_in,
        output sda_in,
        output tx_data,
        input  sda_oe,
        input  busy,
        input  rw,
        input  rx_data,
        input  rx_valid,
        input  tx_req
    );
endinterface
`default_nettype wire

// File: rtl/i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave
//  Purpose  : I2C target endpoint. Oversamples SCL/SDA on ref_clk, detects
//             START/STOP, matches a 7-bit address, ACKs every written byte
//             and hands it to local logic, and shifts out bytes fetched from
//             local logic on master reads. Drives SDA open-drain only and
//             never stretches SCL.
//  Ports    : ref_clk - system clock, all logic on its rising edge
//             reset   - asynchronous, active-low reset
//             bus     - i2c_slave_if.slave (pins + local byte handshake)
//  Params   : ADDR       - 7-bit bus address of this target
//             FILTER_LEN - consecutive equal samples needed to accept a
//                          new SCL/SDA level (>= 1)
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_slave #(
    parameter logic [6:0] ADDR       = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic        ref_clk,
    input  logic        reset,
    i2c_slave_if.slave  bus
);

    localparam int c_CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(FILTER_LEN - 1);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_ADDR      = 3'd1;
    localparam logic [2:0] c_ADDR_ACK  = 3'd2;
    localparam logic [2:0] c_WR        = 3'd3;
    localparam logic [2:0] c_WR_ACK    = 3'd4;
    localparam logic [2:0] c_RD        = 3'd5;
    localparam logic [2:0] c_RD_ACK    = 3'd6;
    localparam logic [2:0] c_WAIT_STOP = 3'd7;

    // ------------------------------------------------------------------
    // Input path: bit 0 = SCL, bit 1 = SDA. Each line gets a two-flop
    // synchronizer followed by a run-length glitch filter.
    // ------------------------------------------------------------------
    logic [1:0] w_pin;
    logic [1:0] w_filt;

    assign w_pin = {bus.sda_in, bus.scl_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic            r_s1;
            logic            r_s2;
            logic            r_lvl;
            logic [c_CW-1:0] r_cnt;

            always_ff @(posedge ref_clk or negedge reset) begin
                if (!reset) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_lvl <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_pin[gi];
                    r_s2 <= r_s1;
                    // Any sample back at the current level restarts the run.
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_filt[gi] = r_lvl;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection on the filtered levels
    // ------------------------------------------------------------------
    logic r_scl_d;
    logic r_sda_d;

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_filt[0];
            r_sda_d <= w_filt[1];
        end
    end

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl      = w_filt[0];
    assign w_sda      = w_filt[1];
    assign w_scl_rise =  w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl &  r_scl_d;
    // SDA may only move while SCL is high to signal START/STOP, so the
    // filtered SCL level alone qualifies the SDA edge.
    assign w_start    = ~w_sda &  r_sda_d & w_scl;
    assign w_stop     =  w_sda & ~r_sda_d & w_scl;

    // ------------------------------------------------------------------
    // Protocol state machine
    // ------------------------------------------------------------------
    logic [2:0] r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_sda_oe;
    logic       r_busy;
    logic       r_rw;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_tx_req;

    logic [7:0] w_shift_in;
    assign w_shift_in = {r_shift[6:0], w_sda};

    always_ff @(posedge ref_clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'd0;
            r_sda_oe   <= 1'b0;
            r_busy     <= 1'b0;
            r_rw       <= 1'b0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_req   <= 1'b0;

            if (w_stop) begin
                // Any partially shifted byte is simply dropped.
                r_state   <= c_IDLE;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= 4'd0;
            end else if (w_start) begin
                // Covers both a first START and a repeated START in any state.
                r_state   <= c_ADDR;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= 4'd0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                    end

                    c_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift <= w_shift_in;
                            if (r_bit_cnt == 4'd7) begin
                                if (w_shift_in[7:1] == ADDR) begin
                                    r_rw      <= w_shift_in[0];
                                    r_busy    <= 1'b1;
                                    r_bit_cnt <= 4'd8;
                                end else begin
                                    r_state   <= c_WAIT_STOP;
                                    r_busy    <= 1'b0;
                                    r_bit_cnt <= 4'd0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            // Matched: pull SDA low for the address ACK.
                            r_state   <= c_ADDR_ACK;
                            r_sda_oe  <= 1'b1;
                            r_bit_cnt <= 4'd0;
                        end
                    end

                    c_ADDR_ACK: begin
                        if (w_scl_rise && r_rw) begin
                            // Half an SCL period for local logic to present tx_data.
                            r_tx_req <= 1'b1;
                        end else if (w_scl_fall) begin
                            if (r_rw) begin
                                r_state   <= c_RD;
                                r_shift   <= bus.tx_data;
                                r_sda_oe  <= ~bus.tx_data[7];
                                r_bit_cnt <= 4'd1;
                            end else begin
                                r_state   <= c_WR;
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 4'd0;
                            end
                        end
                    end

                    c_WR: begin
                        if (w_scl_rise && r_bit_cnt != 4'd8) begin
                            r_shift   <= w_shift_in;
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                            r_sda_oe   <= 1'b1;
                            r_state    <= c_WR_ACK;
                            r_bit_cnt  <= 4'd0;
                        end
                    end

                    c_WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                            r_state  <= c_WR;
                        end
                    end

                    c_RD: begin
                        // r_bit_cnt counts bits already placed on the bus.
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_state   <= c_RD_ACK;
                                r_bit_cnt <= 4'd0;
                            end else begin
                                r_sda_oe  <= ~r_shift[6];
                                r_shift   <= {r_shift[6:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 4'd1;
                            end
                        end
                    end

                    c_RD_ACK: begin
                        if (w_scl_rise) begin
                            if (!w_sda) begin
                                r_tx_req <= 1'b1;
                            end else begin
                                r_state  <= c_WAIT_STOP;
                                r_sda_oe <= 1'b0;
                                r_busy   <= 1'b0;
                            end
                        end else if (w_scl_fall) begin
                            // Only reachable after an ACK; a NACK left on the rise.
                            r_state   <= c_RD;
                            r_shift   <= bus.tx_data;
                            r_sda_oe  <= ~bus.tx_data[7];
                            r_bit_cnt <= 4'd1;
                        end
                    end

                    c_WAIT_STOP: begin
                    end

                    default: begin
                        r_state  <= c_IDLE;
                        r_sda_oe <= 1'b0;
                        r_busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.busy     = r_busy;
    assign bus.rw       = r_rw;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.tx_req   = r_tx_req;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave
//  Purpose  : Self-checking bench for i2c_slave. A bit-banged bus master
//             drives SCL/SDA through an open-drain wired-AND model; a
//             negedge monitor collects rx bytes and answers tx_req from a
//             source queue. Expected bytes are queued as stimulus is driven
//             and compared when the target produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_slave;

    localparam int c_Q = 12;   // quarter SCL period in ref_clk cycles

    logic ref_clk = 1'b0;
    logic reset   = 1'b0;
    logic m_scl   = 1'b1;
    logic m_sda   = 1'b1;

    always #5 ref_clk = ~ref_clk;

    i2c_slave_if bus();

    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;

    i2c_slave #(
        .ADDR       (7'h42),
        .FILTER_LEN (3)
    ) dut (
        .ref_clk (ref_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int         nchk = 0;
    int         nerr = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] rx_obs[$];
    logic [7:0] tx_src[$];
    logic [7:0] rd_exp[$];
    int         tx_req_cnt = 0;
    bit         oe_seen    = 1'b0;
    bit         busy_seen  = 1'b0;

    // Monitor and local-logic responder, away from the active edge.
    always @(negedge ref_clk) begin
        if (bus.rx_valid) rx_obs.push_back(bus.rx_data);
        if (bus.sda_oe)   oe_seen = 1'b1;
        if (bus.busy)     busy_seen = 1'b1;
        if (bus.tx_req) begin
            tx_req_cnt++;
            bus.tx_data = (tx_src.size() > 0) ? tx_src.pop_front() : 8'hFF;
        end
    end

    // ---------------- bus master primitives ----------------
    task automatic wait_q();
        repeat (c_Q) @(negedge ref_clk);
    endtask

    task automatic clk_bit(input logic b, output logic s);
        m_sda = b;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        s = bus.sda_in;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_start();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b0;
        wait_q();
    endtask

    task automatic bus_rstart();
        m_sda = 1'b1;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        bus_start();
    endtask

    task automatic bus_stop();
        m_sda = 1'b0;
        wait_q();
        m_scl = 1'b1;
        wait_q();
        m_sda = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, s);
            b[i] = s;
        end
        clk_bit(mack, s);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(negedge ref_clk);
        nchk++; if (bus.sda_oe   !== 1'b0)  begin nerr++; $display("FAIL reset_sda_oe: got %b expected 0", bus.sda_oe); end
        nchk++; if (bus.busy     !== 1'b0)  begin nerr++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        nchk++; if (bus.rw       !== 1'b0)  begin nerr++; $display("FAIL reset_rw: got %b expected 0", bus.rw); end
        nchk++; if (bus.rx_data  !== 8'h00) begin nerr++; $display("FAIL reset_rx_data: got %h expected 00", bus.rx_data); end
        nchk++; if (bus.rx_valid !== 1'b0)  begin nerr++; $display("FAIL reset_rx_valid: got %b expected 0", bus.rx_valid); end
        nchk++; if (bus.tx_req   !== 1'b0)  begin nerr++; $display("FAIL reset_tx_req: got %b expected 0", bus.tx_req); end
        reset = 1'b1;
        repeat (10) @(negedge ref_clk);
    endtask

    task automatic test_write();
        logic a;
        logic [7:0] e;
        rx_obs.delete();
        bus_start();
        write_byte(8'h84, a);
        nchk++; if (a !== 1'b0) begin nerr++; $display("FAIL wr_addr_ack: got %b expected 0", a); end
        nchk++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL wr_busy_set: got %b expected 1", bus.busy); end
        write_byte(8'hA5, a); rx_exp.push_back(8'hA5);
        nchk++; if (a !== 1'b0) begin nerr++; $display("FAIL wr_data_ack: got %b expected 0", a); end
        bus_stop();
        nchk++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL wr_busy_clear: got %b expected 0", bus.busy); end
        nchk++; if (rx_obs.size() != rx_exp.size()) begin nerr++; $display("FAIL wr_rx_count: got %0d expected %0d", rx_obs.size(), rx_exp.size()); end
        while (rx_exp.size() > 0 && rx_obs.size() > 0) begin
            e = rx_exp.pop_front();
            nchk++; if (rx_obs[0] !== e) begin nerr++; $display("FAIL wr_rx_data: got %h expected %h", rx_obs[0], e); end
            void'(rx_obs.pop_front());
        end
        rx_exp.delete(); rx_obs.delete();
    endtask

    task automatic test_mismatch();
        logic a1, a2;
        oe_seen = 1'b0; busy_seen = 1'b0; tx_req_cnt = 0; rx_obs.delete();
        bus_start();
        write_byte(8'h86, a1);
        write_byte(8'hFF, a2);
        bus_stop();
        nchk++; if (a1 !== 1'b1) begin nerr++; $display("FAIL mm_addr_nack: got %b expected 1", a1); end
        nchk++; if (a2 !== 1'b1) begin nerr++; $display("FAIL mm_data_nack: got %b expected 1", a2); end
        nchk++; if (oe_seen !== 1'b0) begin nerr++; $display("FAIL mm_sda_oe: got %b expected 0", oe_seen); end
        nchk++; if (busy_seen !== 1'b0) begin nerr++; $display("FAIL mm_busy: got %b expected 0", busy_seen); end
        nchk++; if (rx_obs.size() != 0) begin nerr++; $display("FAIL mm_rx_valid: got %0d expected 0", rx_obs.size()); end
        nchk++; if (tx_req_cnt != 0) begin nerr++; $display("FAIL mm_tx_req: got %0d expected 0", tx_req_cnt); end
    endtask

    task automatic test_read();
        logic a;
        logic [7:0] b, e;
        tx_req_cnt = 0;
        tx_src.push_back(8'h3C); rd_exp.push_back(8'h3C);
        tx_src.push_back(8'hC3); rd_exp.push_back(8'hC3);
        bus_start();
        write_byte(8'h85, a);
        nchk++; if (a !== 1'b0) begin nerr++; $display("FAIL rd_addr_ack: got %b expected 0", a); end
        nchk++; if (bus.rw !== 1'b1) begin nerr++; $display("FAIL rd_rw: got %b expected 1", bus.rw); end
        read_byte(1'b0, b);
        e = rd_exp.pop_front();
        nchk++; if (b !== e) begin nerr++; $display("FAIL rd_byte0: got %h expected %h", b, e); end
        read_byte(1'b1, b);
        e = rd_exp.pop_front();
        nchk++; if (b !== e) begin nerr++; $display("FAIL rd_byte1: got %h expected %h", b, e); end
        nchk++; if (bus.sda_oe !== 1'b0) begin nerr++; $display("FAIL rd_oe_after_nack: got %b expected 0", bus.sda_oe); end
        nchk++; if (bus.busy !== 1'b0) begin nerr++; $display("FAIL rd_busy_after_nack: got %b expected 0", bus.busy); end
        bus_stop();
        nchk++; if (tx_req_cnt != 2) begin nerr++; $display("FAIL rd_tx_req_count: got %0d expected 2", tx_req_cnt); end
    endtask

    task automatic test_back_to_back();
        logic a;
        logic [7:0] b, e;
        rx_obs.delete(); rx_exp.delete();
        bus_start();
        write_byte(8'h84, a);
        nchk++; if (a !== 1'b0) begin nerr++; $display("FAIL b2b_waddr_ack: got %b expected 0", a); end
        write_byte(8'h01, a); rx_exp.push_back(8'h01);
        nchk++; if (a !== 1'b0) begin nerr++; $display("FAIL b2b_data_ack: got %b expected 0", a); end
        nchk++; if (bus.rw !== 1'b0) begin nerr++; $display("FAIL b2b_rw_write: got %b expected 0", bus.rw); end
        tx_src.push_back(8'h5A); rd_exp.push_back(8'h5A);
        bus_rstart();
        write_byte(8'h85, a);
        nchk++; if (a !== 1'b0) begin nerr++; $display("FAIL b2b_raddr_ack: got %b expected 0", a); end
        nchk++; if (bus.rw !== 1'b1) begin nerr++; $display("FAIL b2b_rw_read: got %b expected 1", bus.rw); end
        nchk++; if (bus.busy !== 1'b1) begin nerr++; $display("FAIL b2b_busy: got %b expected 1", bus.busy); end
        read_byte(1'b1, b);
        e = rd_exp.pop_front();
        nchk++; if (b !== e) begin nerr++; $display("FAIL b2b_read: got %h expected %h", b, e); end
        bus_stop();
        nchk++; if (rx_obs.size() != rx_exp.size()) begin nerr++; $display("FAIL b2b_rx_count: got %0d expected %0d", rx_obs.size(), rx_exp.size()); end
        while (rx_exp.size() > 0 && rx_obs.size() > 0) begin
            e = rx_exp.pop_front();
            nchk++; if (rx_obs[0] !== e) begin nerr++; $display("FAIL b2b_rx_data: got %h expected %h", rx_obs[0], e); end
            void'(rx_obs.pop_front());
        end
        rx_exp.delete(); rx_obs.delete();
    endtask

    task automatic test_glitch();
        logic a;
        oe_seen = 1'b0; busy_seen = 1'b0;
        @(negedge ref_clk); m_sda = 1'b0;
        @(negedge ref_clk); m_sda = 1'b1;
        wait_q(); wait_q();
        // Clock an address byte with no real START: the target must stay idle.
        m_scl = 1'b0;
        wait_q();
        write_byte(8'h84, a);
        m_scl = 1'b1;
        wait_q(); wait_q();
        nchk++; if (a !== 1'b1) begin nerr++; $display("FAIL glitch_no_ack: got %b expected 1", a); end
        nchk++; if (oe_seen !== 1'b0) begin nerr++; $display("FAIL glitch_sda_oe: got %b expected 0", oe_seen); end
        nchk++; if (busy_seen !== 1'b0) begin nerr++; $display("FAIL glitch_busy: got %b expected 0", busy_seen); end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        int   n;
        tx_src.delete();
        tx_src.push_back(8'h00);
        bus_start();
        write_byte(8'h85, a);
        n = 0;
        while (bus.sda_oe !== 1'b1 && n < 200) begin
            @(negedge ref_clk);
            n++;
        end
        nchk++; if (bus.sda_oe !== 1'b1) begin nerr++; $display("FAIL rst_mid_oe_driven: got %b expected 1 (timeout)", bus.sda_oe); end
        #2 reset = 1'b0;
        #1;
        nchk++; if (bus.sda_oe !== 1'b0) begin nerr++; $display("FAIL rst_mid_async_oe: got %b expected 0", bus.sda_oe); end
        repeat (4) @(negedge ref_clk);
        m_scl = 1'b1; m_sda = 1'b1;
        repeat (4) @(negedge ref_clk);
        reset = 1'b1;
        wait_q(); wait_q();
        nchk++; if (bus.sda_oe   !== 1'b0)  begin nerr++; $display("FAIL rst_mid_sda_oe: got %b expected 0", bus.sda_oe); end
        nchk++; if (bus.busy     !== 1'b0)  begin nerr++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        nchk++; if (bus.rw       !== 1'b0)  begin nerr++; $display("FAIL rst_mid_rw: got %b expected 0", bus.rw); end
        nchk++; if (bus.rx_data  !== 8'h00) begin nerr++; $display("FAIL rst_mid_rx_data: got %h expected 00", bus.rx_data); end
        nchk++; if (bus.rx_valid !== 1'b0)  begin nerr++; $display("FAIL rst_mid_rx_valid: got %b expected 0", bus.rx_valid); end
        nchk++; if (bus.tx_req   !== 1'b0)  begin nerr++; $display("FAIL rst_mid_tx_req: got %b expected 0", bus.tx_req); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_mismatch();
        test_read();
        test_back_to_back();
        test_glitch();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
